// File: rtl/lfsr_checker.sv
// PRBS receive checker: self-synchronises to a 32-bit Fibonacci LFSR stream,
// reports lock state, per-word mismatch pulses and a saturating error count.
module lfsr_checker #(
  parameter logic [31:0] TAPS          = 32'h8020_0003,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned UNLOCK_THRESH = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      data_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [1:0]       state_o
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RUN_MAX = (LOCK_COUNT > UNLOCK_THRESH) ? LOCK_COUNT : UNLOCK_THRESH;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   pred_q, pred_d;
  logic [RUN_W-1:0]    run_q, run_d, run_inc;
  logic [CNT_W-1:0]    cnt_d;
  logic                err_d;
  logic                hit;

  function automatic logic [DATA_W-1:0] nxt(input logic [DATA_W-1:0] s);
    return {s[DATA_W-2:0], ^(s & TAPS)};
  endfunction

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SEARCH;
      pred_q      <= '0;
      run_q       <= '0;
      err_o       <= 1'b0;
      err_count_o <= '0;
      locked_o    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      run_q       <= run_d;
      err_o       <= err_d;
      err_count_o <= cnt_d;
      locked_o    <= (state_d == LOCKED);
    end
  end

  assign state_o = state_q;
  assign run_inc = run_q + RUN_W'(1);
  assign hit     = (data_i == pred_q);

  // Next-state, prediction and error accounting
  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    run_d   = run_q;
    err_d   = 1'b0;
    cnt_d   = err_count_o;
    if (valid_i) begin
      case (state_q)
        SEARCH: begin
          if (data_i != '0) begin
            pred_d  = nxt(data_i);
            run_d   = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            pred_d = nxt(data_i);
            if (run_inc == RUN_W'(LOCK_COUNT)) begin
              run_d   = '0;
              state_d = LOCKED;
            end else begin
              run_d = run_inc;
            end
          end else if (data_i != '0) begin
            pred_d = nxt(data_i);
            run_d  = '0;
          end else begin
            run_d   = '0;
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Track from the prediction so isolated bit errors do not derail it
          pred_d = nxt(pred_q);
          if (hit) begin
            run_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_count_o != {CNT_W{1'b1}}) cnt_d = err_count_o + CNT_W'(1);
            if (run_inc == RUN_W'(UNLOCK_THRESH)) begin
              run_d   = '0;
              state_d = SEARCH;
            end else begin
              run_d = run_inc;
            end
          end
        end
        default: begin
          run_d   = '0;
          state_d = SEARCH;
        end
      endcase
    end
    if (clear_i) cnt_d = '0;
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: hand vectors, directed corner sequences
// and randomized traffic against a behavioural model.
module tb_lfsr_checker;

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam int LOCK_COUNT    = 4;
  localparam int UNLOCK_THRESH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] data_i;
  logic        valid_i;
  logic        clear_i;
  logic        locked_o, err_o;
  logic [15:0] err_count_o;
  logic [1:0]  state_o;
  logic        locked4, err4;
  logic [3:0]  count4;
  logic [1:0]  state4;

  lfsr_checker #(.TAPS(TAPS), .LOCK_COUNT(4), .UNLOCK_THRESH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .clear_i(clear_i),
    .locked_o(locked_o), .err_o(err_o), .err_count_o(err_count_o), .state_o(state_o)
  );

  lfsr_checker #(.TAPS(TAPS), .LOCK_COUNT(4), .UNLOCK_THRESH(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .clear_i(clear_i),
    .locked_o(locked4), .err_o(err4), .err_count_o(count4), .state_o(state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: parity of tapped bits via popcount
  function automatic logic [31:0] nx(input logic [31:0] s);
    return {s[30:0], 1'($countones(s & TAPS) % 2)};
  endfunction

  // Behavioural model; the error count is unbounded and saturated at compare time
  int          m_mode;  // 0 search, 1 verify, 2 locked
  logic [31:0] m_pred;
  int          m_run;
  int          m_cnt;
  bit          m_err;

  task automatic model(input bit r, input bit v, input logic [31:0] d, input bit c);
    bit good;
    m_err = 0;
    if (!r) begin
      m_mode = 0; m_pred = 0; m_run = 0; m_cnt = 0;
      return;
    end
    if (v) begin
      good = (d == m_pred);
      if (m_mode == 0) begin
        if (d != 0) begin m_pred = nx(d); m_run = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (good) begin
          m_pred = nx(d);
          m_run++;
          if (m_run == LOCK_COUNT) begin m_mode = 2; m_run = 0; end
        end else if (d != 0) begin
          m_pred = nx(d); m_run = 0;
        end else begin
          m_mode = 0; m_run = 0;
        end
      end else begin
        m_pred = nx(m_pred);
        if (good) m_run = 0;
        else begin
          m_err = 1; m_cnt++; m_run++;
          if (m_run == UNLOCK_THRESH) begin m_mode = 0; m_run = 0; end
        end
      end
    end
    if (c) m_cnt = 0;
  endtask

  function automatic logic [31:0] sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return 32'((v > mx) ? mx : v);
  endfunction

  task automatic step(input bit r, input bit v, input logic [31:0] d, input bit c);
    @(negedge clk);
    reset = r; valid_i = v; data_i = d; clear_i = c;
    @(posedge clk);
    #1;
    model(r, v, d, c);
    chk("state",  32'(state_o),     32'(m_mode));
    chk("locked", 32'(locked_o),    32'(m_mode == 2));
    chk("err",    32'(err_o),       32'(m_err));
    chk("count",  32'(err_count_o), sat(m_cnt, 16));
    chk("count4", 32'(count4),      sat(m_cnt, 4));
    chk("err4",   32'(err4),        32'(m_err));
  endtask

  typedef struct {
    bit          r, v, c;
    logic [31:0] d;
    logic [1:0]  st;
    bit          lk, er;
    logic [15:0] cnt;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] gen;

  function automatic vec_t mk(bit r, bit v, logic [31:0] d, bit c,
                              logic [1:0] st, bit lk, bit er, logic [15:0] cnt);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.c = c; x.st = st; x.lk = lk; x.er = er; x.cnt = cnt;
    return x;
  endfunction

  initial begin
    reset = 1'b0; valid_i = 1'b0; data_i = '0; clear_i = 1'b0;

    // Clean lock from 0x1, idle, then zero words and a VERIFY reseed from 0x7
    tbl.push_back(mk(0, 1, 32'h1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h1,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h3,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h6,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'hD,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h1B, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,  0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h1,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h3,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h7,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'hE,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h1D, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h3B, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h76, 0, 2, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d_state", i),  32'(state_o),     32'(tbl[i].st));
      chk($sformatf("tbl%0d_locked", i), 32'(locked_o),    32'(tbl[i].lk));
      chk($sformatf("tbl%0d_err", i),    32'(err_o),       32'(tbl[i].er));
      chk($sformatf("tbl%0d_count", i),  32'(err_count_o), 32'(tbl[i].cnt));
    end
    gen = 32'hED;

    // 100 further clean words
    for (int i = 0; i < 100; i++) begin step(1, 1, gen, 0); gen = nx(gen); end
    chk("clean_count", 32'(err_count_o), 32'd0);
    chk("clean_locked", 32'(locked_o), 32'd1);

    // Single corrupted word
    step(1, 1, gen ^ 32'h8000_0000, 0); gen = nx(gen);
    chk("single_err", 32'(err_o), 32'd1);
    chk("single_count", 32'(err_count_o), 32'd1);
    chk("single_locked", 32'(locked_o), 32'd1);
    step(1, 1, gen, 0); gen = nx(gen);
    chk("single_after_err", 32'(err_o), 32'd0);
    chk("single_after_count", 32'(err_count_o), 32'd1);

    // Loss of lock after four consecutive bad words, then relock
    step(1, 1, gen, 1); gen = nx(gen);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, ~gen, 0); gen = nx(gen);
      chk("loss_err", 32'(err_o), 32'd1);
      chk("loss_locked", 32'(locked_o), 32'(i < 3));
    end
    chk("loss_count", 32'(err_count_o), 32'd4);
    chk("loss_state", 32'(state_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, gen, 0); gen = nx(gen);
      chk("relock", 32'(locked_o), 32'(i == 4));
    end

    // Saturation of the 4-bit counter, then clear colliding with an error
    step(1, 1, gen, 1); gen = nx(gen);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, gen ^ 32'h1, 0); gen = nx(gen);
      step(1, 1, gen, 0); gen = nx(gen);
    end
    chk("sat_count4", 32'(count4), 32'hF);
    chk("sat_count16", 32'(err_count_o), 32'd20);
    chk("sat_locked", 32'(locked_o), 32'd1);
    step(1, 1, gen ^ 32'h10, 1); gen = nx(gen);
    chk("clr_err", 32'(err_o), 32'd1);
    chk("clr_count4", 32'(count4), 32'd0);
    chk("clr_count16", 32'(err_count_o), 32'd0);
    step(1, 1, gen, 0); gen = nx(gen);

    // Random valid gaps in a clean stream
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(9, 0) < 7) begin step(1, 1, gen, 0); gen = nx(gen); end
      else step(1, 0, $urandom, 0);
    end
    chk("gap_count", 32'(err_count_o), 32'd0);
    chk("gap_locked", 32'(locked_o), 32'd1);

    // Reset while locked, then relock
    step(0, 1, gen, 0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_locked", 32'(locked_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_count", 32'(err_count_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, gen, 0); gen = nx(gen);
      chk("rst_relock", 32'(locked_o), 32'(i == 4));
    end

    // Randomized mix of errors, bursts, zeros, gaps, clears and resets
    for (int i = 0; i < 2000; i++) begin
      int roll;
      logic [31:0] w;
      roll = $urandom_range(99, 0);
      w = gen;
      if (roll < 8) w = gen ^ (32'h1 << $urandom_range(31, 0));
      else if (roll < 11) w = $urandom;
      else if (roll < 13) w = 32'h0;
      if ($urandom_range(99, 0) < 25) step(1, 0, $urandom, $urandom_range(99, 0) < 3);
      else begin
        step($urandom_range(199, 0) != 0, 1, w, $urandom_range(99, 0) < 3);
        gen = nx(gen);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side counterpart of the free-running 32-bit LFSR generator: it consumes the generator's state words, self-synchronises to the sequence, and reports lock status and mismatches. It sits at the far end of a link or datapath under test, so the generator/checker pair forms a PRBS integrity test. The block carries its own copy of the LFSR next-state function and predicts each incoming word. It declares lock after a run of correct words and drops lock after a run of bad ones.

## Interface
- TAPS, 32'h8020_0003, feedback tap mask; must equal the generator's.
- LOCK_COUNT, 4, consecutive correct words needed to declare lock (≥1).
- UNLOCK_THRESH, 4, consecutive mismatching words in LOCKED that force resync (≥1).
- CNT_W, 16, error counter width.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- data_i  in  32  received LFSR state word.
- valid_i  in  1  data_i is valid this cycle; one word equals one generator step.
- clear_i  in  1  synchronous clear of err_count_o.
- locked_o  out  1  checker in LOCKED state.
- err_o  out  1  one-cycle pulse per mismatching word while LOCKED.
- err_count_o  out  CNT_W  saturating count of mismatches while LOCKED.
- state_o  out  2  FSM state: 0 SEARCH, 1 VERIFY, 2 LOCKED.

## Operation
- Next-state function (Fibonacci, left shift): nxt(s) = {s[30:0], ^(s & TAPS)}. Example: 0x1→0x3→0x6→0xD→0x1B.
- Internal registers:
  - pred: 32-bit predicted next word.
  - run: consecutive-match counter, or consecutive-miss counter in LOCKED.
  - err_count: error counter.
- Only cycles with valid_i=1 are processed. Idle cycles change nothing.
- SEARCH:
  - Non-zero word: pred←nxt(data_i), run←0, go to VERIFY.
  - Word of 0x0000_0000 (illegal LFSR state): ignored, stay in SEARCH.
- VERIFY:
  - Match (data_i==pred): pred←nxt(data_i), run←run+1. When run+1==LOCK_COUNT, go to LOCKED with run←0.
  - Mismatch: resync. A non-zero word gives pred←nxt(data_i), run←0, stay in VERIFY. A zero word goes to SEARCH.
- LOCKED:
  - pred always advances from the prediction, pred←nxt(pred), never from data_i. Isolated bit errors therefore do not derail tracking.
  - Match: run←0.
  - Mismatch: err_o pulse, err_count+1 (saturates at all-ones), run←run+1. When run+1==UNLOCK_THRESH, go to SEARCH.
- Mismatches in SEARCH and VERIFY never pulse err_o or increment err_count.
- clear_i has priority over a same-cycle increment: the result is 0 and the error is not counted. err_o still pulses.
- Mismatches are counted per word, not per bit.

## Timing
- Reset (reset=0 at a clk edge) puts all outputs to 0: locked_o=0, err_o=0, err_count_o=0, state_o=0 (SEARCH). pred and run are also cleared.
- Reset applied mid-operation, including while LOCKED, behaves identically; the block resyncs from scratch afterwards.
- All outputs are registered. The effect of a word sampled at edge N appears right after edge N.
- Lock latency from reset release with continuous valid words:
  - 1 load word plus LOCK_COUNT matching words.
  - locked_o rises after the edge that samples word LOCK_COUNT+1, i.e. the 5th word with defaults.
- err_o is high for exactly one cycle per mismatching word, including on back-to-back mismatches.
- Unlock latency: locked_o and state_o change after the edge sampling the UNLOCK_THRESH-th consecutive mismatch.
  - That word still pulses err_o and counts.
- valid_i gaps while LOCKED do not advance pred. The generator is expected to gate its stepping with the same valid.

## Test plan
- Clean lock: reset, then words 0x1,0x3,0x6,0xD,0x1B,… → state_o 0→1 after the 1st word, locked_o=1 after the 5th, err_count_o=0 after 100 further words.
- Single error while LOCKED: corrupt one word (XOR 0x8000_0000) → err_o pulses once, err_count_o=1, locked_o stays 1; the next correct word matches with no further error.
- Loss of lock: while LOCKED, inject 4 consecutive wrong words → err_count_o=4 and locked_o=0 after the 4th; resuming the clean sequence relocks after 5 words.
- Zero and VERIFY resync: feed 0x0 three times → state stays SEARCH. Then 0x1, 0x3, 0x7 (bad) → stays VERIFY and reseeds from 0x7, no err_o, err_count_o unchanged. Then nxt chain from 0x7 → lock.
- Counter saturation and clear: with CNT_W=4 and locked, 20 single errors each separated by a correct word → err_count_o holds 0xF. clear_i asserted in the same cycle as an error → err_count_o=0 and err_o=1.
- Valid gaps and reset mid-lock: random valid_i=0 gaps in a clean stream → no errors. Assert reset while LOCKED → all outputs 0 on the next cycle, then relock after 5 words.
